// File: rtl/ctl_game_round.sv
// ctl_game_round: round/turn sequencer for a hot-seat duck-shooting game.
// Launches ducks, counts shots and hits per turn, and keeps two-digit BCD scores
// for each player. Players who score too few hits in a turn are eliminated.
// All outputs are registered.
// Optional build macro CTL_GAME_PERFECT_BONUS_EN: a turn in which every duck is
// hit earns an extra 10 points, saturating at 99.
module ctl_game_round #(
    parameter int N_PLAYERS       = 2,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int PASS_HITS       = 6,
    parameter int MAX_ROUNDS      = 5,
    parameter int INTRO_FRAMES    = 60,
    parameter int RESULT_FRAMES   = 30
) (
    input  logic                   clk_i,
    input  logic                   rst_i,          // asynchronous, active low
    input  logic                   new_frame_i,
    input  logic                   start_i,
    input  logic                   hit_i,
    input  logic                   shot_fired_i,
    input  logic                   duck_escaped_i,
    output logic                   duck_launch_o,
    output logic                   duck_flee_o,
    output logic [1:0]             active_player_o,
    output logic [3:0]             round_num_o,
    output logic [2:0]             shots_left_o,
    output logic [8*N_PLAYERS-1:0] scores_o,
    output logic [N_PLAYERS-1:0]   eliminated_o,
    output logic                   pause_o,
    output logic                   looser_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INTRO     = 3'd1,
        LAUNCH    = 3'd2,
        FLIGHT    = 3'd3,
        RESULT    = 3'd4,
        TURN_END  = 3'd5,
        GAME_OVER = 3'd6
    } state_t;

    localparam int FMAX = (INTRO_FRAMES > RESULT_FRAMES) ? INTRO_FRAMES : RESULT_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    localparam logic [FW-1:0] INTRO_LAST  = FW'(INTRO_FRAMES - 1);
    localparam logic [FW-1:0] RESULT_LAST = FW'(RESULT_FRAMES - 1);
    localparam logic [3:0]    DUCKS_L     = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0]    PASS_L      = 4'(PASS_HITS);
    localparam logic [2:0]    SHOTS_L     = 3'(SHOTS_PER_DUCK);
    localparam logic [4:0]    MAXR_L      = 5'(MAX_ROUNDS);

    state_t                   state_q;
    logic [FW-1:0]            frame_cnt_q;
    logic [3:0]               ducks_done_q;
    logic [3:0]               turn_hits_q;
    logic [8*N_PLAYERS-1:0]   scores_q;
    logic [N_PLAYERS-1:0]     elim_q;
    logic [1:0]               active_q;
    logic [3:0]               round_q;
    logic [2:0]               shots_q;
    logic                     launch_q;
    logic                     flee_q;
    logic                     pause_q;
    logic                     looser_q;

    // Next-turn bookkeeping derived from the current turn's results
    logic [N_PLAYERS-1:0]     elim_d;
    logic [1:0]               next_active_d;
    logic                     wrap_d;
    logic                     any_left_d;
    logic [4:0]               round_d;
    logic                     game_end_d;
    logic [7:0]               cur_score;

    // BCD +1 with saturation at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)            return s;
        else if (s[3:0] == 4'd9)   return {s[7:4] + 4'd1, 4'd0};
        else                       return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // BCD +10 with saturation at 99
    function automatic logic [7:0] bcd_add10(input logic [7:0] s);
        if (s[7:4] == 4'd9) return 8'h99;
        else                return {s[7:4] + 4'd1, s[3:0]};
    endfunction

    // Elimination result and search for the next surviving player (wrapping)
    always_comb begin
        elim_d        = elim_q;
        next_active_d = active_q;
        wrap_d        = 1'b0;
        any_left_d    = 1'b0;
        cur_score     = scores_q[8*int'(active_q) +: 8];
        if (turn_hits_q < PASS_L) begin
            elim_d = elim_q | (N_PLAYERS'(1) << active_q);
        end
        for (int k = 1; k <= N_PLAYERS; k++) begin
            int   idx;
            logic w;
            idx = int'(active_q) + k;
            w   = (idx >= N_PLAYERS);
            if (w) idx = idx - N_PLAYERS;
            if (!any_left_d && !elim_d[idx]) begin
                any_left_d    = 1'b1;
                next_active_d = 2'(idx);
                wrap_d        = w;
            end
        end
        round_d    = {1'b0, round_q} + {4'd0, wrap_d};
        game_end_d = !any_left_d || (round_d > MAXR_L);
    end

    // Game sequencer: state, counters, scores and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            ducks_done_q <= '0;
            turn_hits_q  <= '0;
            scores_q     <= '0;
            elim_q       <= '0;
            active_q     <= '0;
            round_q      <= '0;
            shots_q      <= '0;
            launch_q     <= 1'b0;
            flee_q       <= 1'b0;
            pause_q      <= 1'b1;
            looser_q     <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            flee_q   <= 1'b0;
            case (state_q)
                IDLE, GAME_OVER: begin
                    pause_q <= 1'b1;
                    if (start_i) begin
                        round_q     <= 4'd1;
                        active_q    <= '0;
                        scores_q    <= '0;
                        elim_q      <= '0;
                        looser_q    <= 1'b0;
                        frame_cnt_q <= '0;
                        state_q     <= INTRO;
                    end
                end
                INTRO: begin
                    if (new_frame_i) begin
                        if (frame_cnt_q == INTRO_LAST) begin
                            frame_cnt_q  <= '0;
                            turn_hits_q  <= '0;
                            ducks_done_q <= '0;
                            pause_q      <= 1'b0;
                            state_q      <= LAUNCH;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    launch_q     <= 1'b1;
                    shots_q      <= SHOTS_L;
                    ducks_done_q <= ducks_done_q + 4'd1;
                    state_q      <= FLIGHT;
                end
                FLIGHT: begin
                    // A hit outranks a simultaneous shot or escape; an escape
                    // outranks a simultaneous last shot, so no flee follows it.
                    if (hit_i) begin
                        scores_q[8*int'(active_q) +: 8] <= bcd_inc(cur_score);
                        turn_hits_q <= turn_hits_q + 4'd1;
                        pause_q     <= 1'b1;
                        state_q     <= RESULT;
                    end else if (duck_escaped_i) begin
                        pause_q <= 1'b1;
                        state_q <= RESULT;
                    end else if (shot_fired_i && shots_q != 3'd0) begin
                        shots_q <= shots_q - 3'd1;
                        if (shots_q == 3'd1) flee_q <= 1'b1;
                    end
                end
                RESULT: begin
                    if (new_frame_i) begin
                        if (frame_cnt_q == RESULT_LAST) begin
                            frame_cnt_q <= '0;
                            pause_q     <= 1'b0;
                            state_q     <= (ducks_done_q < DUCKS_L) ? LAUNCH : TURN_END;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                TURN_END: begin
                    elim_q  <= elim_d;
                    pause_q <= 1'b1;
`ifdef CTL_GAME_PERFECT_BONUS_EN
                    if (turn_hits_q == DUCKS_L) begin
                        scores_q[8*int'(active_q) +: 8] <= bcd_add10(cur_score);
                    end
`endif
                    if (any_left_d) active_q <= next_active_d;
                    if (game_end_d) begin
                        looser_q <= &elim_d;
                        state_q  <= GAME_OVER;
                    end else begin
                        round_q     <= round_d[3:0];
                        frame_cnt_q <= '0;
                        state_q     <= INTRO;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign duck_launch_o   = launch_q;
    assign duck_flee_o     = flee_q;
    assign active_player_o = active_q;
    assign round_num_o     = round_q;
    assign shots_left_o    = shots_q;
    assign scores_o        = scores_q;
    assign eliminated_o    = elim_q;
    assign pause_o         = pause_q;
    assign looser_o        = looser_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_ctl_game_round.sv
// Bench for ctl_game_round: game-level reference model feeding an expected
// queue, with a monitor that pops and compares on each observable DUT event.
module tb_ctl_game_round;

    localparam int NP = 2, DUCKS = 10, SHOTS = 3, PASS = 6, MAXR = 11;
    localparam int INTROF = 2, RESF = 2;
    localparam int W = 36;
    localparam logic [2:0] S_IDLE = 3'd0, S_INTRO = 3'd1, S_FLIGHT = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4, S_TEND = 3'd5, S_OVER = 3'd6;

    logic        clk, rst, new_frame, start, hit, shot, esc;
    logic        duck_launch, duck_flee, pause, looser;
    logic [1:0]  active;
    logic [3:0]  round_num;
    logic [2:0]  shots_left, state;
    logic [15:0] scores;
    logic [1:0]  elim;

    ctl_game_round #(
        .N_PLAYERS(NP), .DUCKS_PER_ROUND(DUCKS), .SHOTS_PER_DUCK(SHOTS),
        .PASS_HITS(PASS), .MAX_ROUNDS(MAXR), .INTRO_FRAMES(INTROF),
        .RESULT_FRAMES(RESF)
    ) dut (
        .clk_i(clk), .rst_i(rst), .new_frame_i(new_frame), .start_i(start),
        .hit_i(hit), .shot_fired_i(shot), .duck_escaped_i(esc),
        .duck_launch_o(duck_launch), .duck_flee_o(duck_flee),
        .active_player_o(active), .round_num_o(round_num),
        .shots_left_o(shots_left), .scores_o(scores), .eliminated_o(elim),
        .pause_o(pause), .looser_o(looser), .state_o(state)
    );

    int checks = 0, errors = 0;
    logic [W-1:0] exp_q[$];

    // reference model (game level)
    int m_score[NP];
    bit m_elim[NP];
    int m_active, m_round, m_hits, m_ducks = 0;
    bit m_over;
    int launch_cnt = 0;
    int icnt = 0, rcnt = 0;
    logic [2:0] prev_state = S_IDLE;

    // clock and frame tick
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int f;
        f = 0;
        new_frame = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            new_frame = (f == 0);
            f = (f + 1) % 3;
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [15:0] m_scores();
        return {to_bcd(m_score[1]), to_bcd(m_score[0])};
    endfunction

    function automatic logic [1:0] m_elim_vec();
        return {m_elim[1], m_elim[0]};
    endfunction

    function automatic logic [W-1:0] mk_rec(input logic [3:0] tag, input logic [2:0] st,
            input logic [1:0] act, input logic [3:0] rnd, input logic [2:0] sh,
            input logic [1:0] el, input logic lo, input logic pa, input logic [15:0] sc);
        return {tag, st, act, rnd, sh, el, lo, pa, sc};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string nm, input logic [W-1:0] got);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event got=%h expected=none at %0t", nm, got, $time);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s got=%h expected=%h at %0t", nm, got, e, $time);
            end
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // monitor: turns DUT activity into records and checks them against the queue
    always @(negedge clk) begin
        if (!rst) begin
            prev_state = S_IDLE;
            icnt = 0;
            rcnt = 0;
        end else begin
            if (duck_launch) launch_cnt++;
            if (duck_flee)
                cmp_obs("flee", mk_rec(4'd1, 3'd0, active, 4'd0, shots_left, 2'd0, 1'b0, 1'b0, scores));
            if (state == S_RESULT && prev_state != S_RESULT)
                cmp_obs("result", mk_rec(4'd2, 3'd0, active, 4'd0, shots_left, 2'd0, 1'b0, pause, scores));
            if (prev_state == S_TEND && state != S_TEND)
                cmp_obs("turn_end", mk_rec(4'd3, state, active, round_num, 3'd0, elim, looser, pause, scores));
            if (prev_state == S_INTRO && state != S_INTRO)
                chk("intro_frames", W'(icnt), W'(INTROF));
            if (prev_state == S_RESULT && state != S_RESULT)
                chk("result_frames", W'(rcnt), W'(RESF));
            if (state != S_INTRO) icnt = 0;
            else if (new_frame) icnt++;
            if (state != S_RESULT) rcnt = 0;
            else if (new_frame) rcnt++;
            prev_state = state;
        end
    end

    // wait for a state; optionally toggle hit/shot while not in flight
    task automatic wait_state(input logic [2:0] tgt, input bit noise);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (state == tgt) begin
                hit = 1'b0;
                shot = 1'b0;
                return;
            end
            if (noise && state != S_FLIGHT) begin
                hit  = ($urandom_range(0, 3) == 0);
                shot = ($urandom_range(0, 3) == 0);
            end else begin
                hit  = 1'b0;
                shot = 1'b0;
            end
        end
        hit = 1'b0;
        shot = 1'b0;
        checks++;
        errors++;
        $display("FAIL wait_state got=%0d expected=%0d (timeout)", state, tgt);
        finish_run();
    endtask

    task automatic pulse(input logic h, input logic s, input logic e);
        @(negedge clk);
        hit = h; shot = s; esc = e;
        @(negedge clk);
        hit = 1'b0; shot = 1'b0; esc = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // one duck: pick a scenario, predict its outcome, then drive it
    task automatic do_duck(input bit want_hit);
        int k, v, sh;
        bit flee;
        flee = 1'b0;
        v = $urandom_range(0, 2);
        if (want_hit) begin
            k = (v == 1) ? SHOTS - 1 : $urandom_range(0, SHOTS - 1);
            sh = SHOTS - k;
            m_score[m_active] = (m_score[m_active] + 1 > 99) ? 99 : m_score[m_active] + 1;
            m_hits++;
        end else begin
            if (v == 0) begin
                k = $urandom_range(0, SHOTS - 1);
                sh = SHOTS - k;
            end else if (v == 1) begin
                k = SHOTS + $urandom_range(0, 2);
                sh = 0;
                flee = 1'b1;
            end else begin
                k = SHOTS - 1;
                sh = 1;
            end
        end
        if (flee)
            exp_q.push_back(mk_rec(4'd1, 3'd0, 2'(m_active), 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, m_scores()));
        exp_q.push_back(mk_rec(4'd2, 3'd0, 2'(m_active), 4'd0, 3'(sh), 2'd0, 1'b0, 1'b1, m_scores()));
        m_ducks++;
        wait_state(S_FLIGHT, 1'b1);
        for (int i = 0; i < k; i++) pulse(1'b0, 1'b1, 1'b0);
        if (want_hit) begin
            if (v == 0)      pulse(1'b1, 1'b0, 1'b0);
            else if (v == 1) pulse(1'b1, 1'b1, 1'b0);
            else             pulse(1'b1, 1'b0, 1'b1);
        end else begin
            if (v == 2) pulse(1'b0, 1'b1, 1'b1);
            else        pulse(1'b0, 1'b0, 1'b1);
        end
    endtask

    // policy: 0 random, 1 all hits, 2 all misses, 3 first six hit
    function automatic bit want(input int pol, input int d);
        case (pol)
            1: return 1'b1;
            2: return 1'b0;
            3: return d < 6;
            default: return $urandom_range(0, 99) < 65;
        endcase
    endfunction

    task automatic model_init();
        for (int p = 0; p < NP; p++) begin
            m_score[p] = 0;
            m_elim[p] = 1'b0;
        end
        m_active = 0;
        m_round = 1;
        m_over = 1'b0;
    endtask

    task automatic model_turn_end();
        int nxt;
        bit found, wrapped;
        found = 1'b0;
        wrapped = 1'b0;
        nxt = m_active;
        if (m_hits < PASS) m_elim[m_active] = 1'b1;
`ifdef CTL_GAME_PERFECT_BONUS_EN
        if (m_hits == DUCKS)
            m_score[m_active] = (m_score[m_active] + 10 > 99) ? 99 : m_score[m_active] + 10;
`endif
        for (int k = 1; k <= NP; k++) begin
            int c;
            c = (m_active + k) % NP;
            if (!found && !m_elim[c]) begin
                found = 1'b1;
                nxt = c;
                wrapped = (m_active + k) >= NP;
            end
        end
        m_active = nxt;
        m_over = !found || (m_round + int'(wrapped) > MAXR);
        if (!m_over) m_round = m_round + int'(wrapped);
        exp_q.push_back(mk_rec(4'd3, m_over ? S_OVER : S_INTRO, 2'(m_active), 4'(m_round),
                               3'd0, m_elim_vec(), m_over && !found, 1'b1, m_scores()));
    endtask

    task automatic run_game(input int pol0, input int pol1);
        model_init();
        pulse_start();
        while (!m_over) begin
            m_hits = 0;
            for (int d = 0; d < DUCKS; d++)
                do_duck(want((m_active == 0) ? pol0 : pol1, d));
            model_turn_end();
        end
        wait_state(S_OVER, 1'b1);
        repeat (4) @(negedge clk);
        chk("over_scores", W'(scores), W'(m_scores()));
        chk("over_looser", W'(looser), W'(m_elim[0] && m_elim[1]));
        chk("over_pause", W'(pause), W'(1));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; hit = 1'b0; shot = 1'b0; esc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", W'(state), W'(S_IDLE));
        chk("rst_pause", W'(pause), W'(1));
        chk("rst_scores", W'(scores), W'(0));
        chk("rst_round", W'(round_num), W'(0));
        chk("rst_misc", W'({duck_launch, duck_flee, looser, elim, active, shots_left}), W'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_game(3, 1);   // exact pass for P0, perfect turns for P1
        run_game(1, 2);   // P1 out at once, P0 saturates at 99
        run_game(2, 2);   // everyone eliminated
        run_game(0, 0);
        run_game(0, 0);
        run_game(0, 0);

        chk("queue_empty", W'(exp_q.size()), W'(0));
        chk("launch_count", W'(launch_cnt), W'(m_ducks));

        // reset in the middle of a flight after some points were scored
        model_init();
        m_hits = 0;
        pulse_start();
        for (int d = 0; d < 3; d++) do_duck(1'b1);
        wait_state(S_FLIGHT, 1'b0);
        chk("pre_rst_scores", W'(scores), W'(m_scores()));
        pulse(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_state", W'(state), W'(S_IDLE));
        chk("mid_rst_scores", W'(scores), W'(0));
        chk("mid_rst_pause", W'(pause), W'(1));
        chk("mid_rst_round", W'({round_num, shots_left, active}), W'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_pulses", W'({duck_launch, duck_flee}), W'(0));
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", W'({state, pause}), W'({S_IDLE, 1'b1}));
        chk("post_rst_queue", W'(exp_q.size()), W'(0));
        finish_run();
    end

endmodule
